// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory bus arbiter.
package mem_arbiter_pkg;

    // Bus word types shared with the rest of the core
    typedef logic [31:0] MemAddrBus;
    typedef logic [31:0] MemBus;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Which requester owns the transaction in flight
    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } arb_owner_t;

    // Default number of back-to-back data grants tolerated while a fetch waits
    localparam int ARB_STARVE_LIMIT_DEFAULT = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Arbiter sharing one memory bus between instruction fetch and data load/store.
// One transaction in flight at a time; data has priority, but fetch is forced
// through after STARVE_LIMIT consecutive data grants while fetch is pending.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = ARB_STARVE_LIMIT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_valid_o,

    input  logic              d_req_i,
    input  logic [3:0]        d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_valid_o,

    output logic              bus_req_o,
    output logic [3:0]        bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic              bus_gnt_i,
    input  logic              bus_rvalid_i,
    input  logic [DATA_W-1:0] bus_rdata_i,

    output logic              busy_o
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    arb_state_t        state_q, state_d;
    arb_owner_t        owner_q, owner_d;
    logic [3:0]        starve_cnt_q, starve_cnt_d;
    logic              bus_req_q, bus_req_d;
    logic [3:0]        bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic              fetch_wins;

    // Next-state logic: arbitrate and capture in IDLE, wait for grant, wait for response
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        starve_cnt_d = starve_cnt_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        fetch_wins   = 1'b0;

        case (state_q)
            IDLE: begin
                if (if_req_i || d_req_i) begin
                    fetch_wins = if_req_i && (!d_req_i || (starve_cnt_q == LIMIT));
                    if (fetch_wins) begin
                        owner_d      = FETCH;
                        bus_we_d     = 4'h0;
                        bus_addr_d   = if_addr_i;
                        bus_wdata_d  = '0;
                        starve_cnt_d = 4'd0;
                    end else begin
                        owner_d     = DATA;
                        bus_we_d    = d_we_i;
                        bus_addr_d  = d_addr_i;
                        bus_wdata_d = d_wdata_i;
                        if (if_req_i) begin
                            starve_cnt_d = (starve_cnt_q == LIMIT) ? starve_cnt_q
                                                                   : starve_cnt_q + 4'd1;
                        end else begin
                            starve_cnt_d = 4'd0;
                        end
                    end
                    bus_req_d = 1'b1;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (bus_gnt_i) begin
                    bus_req_d = 1'b0;
                    state_d   = RESP;
                end
            end
            RESP: begin
                if (bus_rvalid_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    // State and captured bus fields; reset drops any transaction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= FETCH;
            starve_cnt_q <= 4'd0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 4'h0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
        end
    end

    // Route the slave response to the owner; writes return zero data
    always_comb begin
        if_valid_o = 1'b0;
        d_valid_o  = 1'b0;
        if_rdata_o = '0;
        d_rdata_o  = '0;
        if ((state_q == RESP) && bus_rvalid_i) begin
            if (owner_q == FETCH) begin
                if_valid_o = 1'b1;
                if_rdata_o = bus_rdata_i;
            end else begin
                d_valid_o = 1'b1;
                if (bus_we_q == 4'h0) begin
                    d_rdata_o = bus_rdata_i;
                end
            end
        end
    end

    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = bus_we_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_wdata_o = bus_wdata_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with STARVE_LIMIT = 4.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_valid_o;
    logic        d_req_i;
    logic [3:0]  d_we_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic [31:0] d_rdata_o;
    logic        d_valid_o;
    logic        bus_req_o;
    logic [3:0]  bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic        bus_gnt_i;
    logic        bus_rvalid_i;
    logic [31:0] bus_rdata_i;
    logic        busy_o;

    int testsRun;
    int testsFailed;

    mem_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .STARVE_LIMIT(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .if_req_i(if_req_i),
        .if_addr_i(if_addr_i),
        .if_rdata_o(if_rdata_o),
        .if_valid_o(if_valid_o),
        .d_req_i(d_req_i),
        .d_we_i(d_we_i),
        .d_addr_i(d_addr_i),
        .d_wdata_i(d_wdata_i),
        .d_rdata_o(d_rdata_o),
        .d_valid_o(d_valid_o),
        .bus_req_o(bus_req_o),
        .bus_we_o(bus_we_o),
        .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o),
        .bus_gnt_i(bus_gnt_i),
        .bus_rvalid_i(bus_rvalid_i),
        .bus_rdata_i(bus_rdata_i),
        .busy_o(busy_o)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic ifReq, input logic [31:0] ifAddr,
                                 input logic dReq, input logic [3:0] dWe,
                                 input logic [31:0] dAddr, input logic [31:0] dWdata);
        if_req_i  = ifReq;
        if_addr_i = ifAddr;
        d_req_i   = dReq;
        d_we_i    = dWe;
        d_addr_i  = dAddr;
        d_wdata_i = dWdata;
    endtask

    // Run one zero-wait-state transaction; caller is in an IDLE cycle with requests driven
    task automatic runTxn(input string tag, input logic expFetch, input logic [31:0] expAddr,
                          input logic [3:0] expWe, input logic [31:0] expWdata,
                          input logic [31:0] rsp);
        tick();
        checkOutput({tag, " state REQ"}, 32'(dut.state_q), 32'(REQ));
        checkOutput({tag, " bus_req"}, 32'(bus_req_o), 32'd1);
        checkOutput({tag, " bus_addr"}, bus_addr_o, expAddr);
        checkOutput({tag, " bus_we"}, 32'(bus_we_o), 32'(expWe));
        checkOutput({tag, " bus_wdata"}, bus_wdata_o, expWdata);
        bus_gnt_i = 1'b1;
        tick();
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = rsp;
        #1;
        checkOutput({tag, " bus_req dropped"}, 32'(bus_req_o), 32'd0);
        checkOutput({tag, " if_valid"}, 32'(if_valid_o), 32'(expFetch));
        checkOutput({tag, " d_valid"}, 32'(d_valid_o), 32'(!expFetch));
        if (expFetch) begin
            checkOutput({tag, " if_rdata"}, if_rdata_o, rsp);
        end else begin
            checkOutput({tag, " d_rdata"}, d_rdata_o, (expWe == 4'h0) ? rsp : 32'h0);
        end
        tick();
        bus_rvalid_i = 1'b0;
        bus_rdata_i  = 32'h0;
        #1;
        checkOutput({tag, " back to IDLE"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        testsRun     = 0;
        testsFailed  = 0;
        rst_n        = 1'b0;
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = 1'b0;
        bus_rdata_i  = 32'h0;
        applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        #12;

        // Reset state
        checkOutput("reset state", 32'(dut.state_q), 32'(IDLE));
        checkOutput("reset bus_req", 32'(bus_req_o), 32'd0);
        checkOutput("reset bus_we", 32'(bus_we_o), 32'd0);
        checkOutput("reset bus_addr", bus_addr_o, 32'h0);
        checkOutput("reset bus_wdata", bus_wdata_o, 32'h0);
        checkOutput("reset if_valid", 32'(if_valid_o), 32'd0);
        checkOutput("reset d_valid", 32'(d_valid_o), 32'd0);
        checkOutput("reset if_rdata", if_rdata_o, 32'h0);
        checkOutput("reset d_rdata", d_rdata_o, 32'h0);
        checkOutput("reset busy", 32'(busy_o), 32'd0);
        checkOutput("reset owner", 32'(dut.owner_q), 32'(FETCH));
        checkOutput("reset starve", 32'(dut.starve_cnt_q), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Fetch-only read, minimum latency: valid in cycle 3
        applyStimulus(1'b1, 32'h0000_0010, 1'b0, 4'h0, 32'h0, 32'h0);
        runTxn("fetch only", 1'b1, 32'h0000_0010, 4'h0, 32'h0, 32'h0013_0000);
        applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        checkOutput("fetch only starve", 32'(dut.starve_cnt_q), 32'd0);

        // Simultaneous requests: data store first, then fetch
        applyStimulus(1'b1, 32'h0000_0020, 1'b1, 4'hF, 32'h0000_0100, 32'hDEAD_BEEF);
        runTxn("simul data", 1'b0, 32'h0000_0100, 4'hF, 32'hDEAD_BEEF, 32'h1234_5678);
        checkOutput("simul starve after data", 32'(dut.starve_cnt_q), 32'd1);
        applyStimulus(1'b1, 32'h0000_0020, 1'b0, 4'h0, 32'h0, 32'h0);
        runTxn("simul fetch", 1'b1, 32'h0000_0020, 4'h0, 32'h0, 32'h0000_0013);
        checkOutput("simul starve after fetch", 32'(dut.starve_cnt_q), 32'd0);

        // Starvation: four data grants, one forced fetch, then data again
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h0000_0040, 1'b1, 4'h0, 32'h300 + 32'(4 * i), 32'h0);
            runTxn($sformatf("starve data%0d", i), 1'b0, 32'h300 + 32'(4 * i), 4'h0, 32'h0,
                   32'hA0 + 32'(i));
            checkOutput($sformatf("starve cnt%0d", i), 32'(dut.starve_cnt_q), 32'(i + 1));
        end
        applyStimulus(1'b1, 32'h0000_0040, 1'b1, 4'h0, 32'h310, 32'h0);
        runTxn("starve forced fetch", 1'b1, 32'h0000_0040, 4'h0, 32'h0, 32'h0000_0B0B);
        checkOutput("starve cnt after fetch", 32'(dut.starve_cnt_q), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1, 4'h0, 32'h310, 32'h0);
        runTxn("starve data resumes", 1'b0, 32'h310, 4'h0, 32'h0, 32'hA4);
        checkOutput("starve cnt data resumes", 32'(dut.starve_cnt_q), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);

        // Slave wait states: 5 cycles without grant, 3 cycles without response
        applyStimulus(1'b0, 32'h0, 1'b1, 4'h0, 32'h0000_0200, 32'h0);
        tick();
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("wait req%0d bus_req", i), 32'(bus_req_o), 32'd1);
            checkOutput($sformatf("wait req%0d bus_addr", i), bus_addr_o, 32'h0000_0200);
            checkOutput($sformatf("wait req%0d busy", i), 32'(busy_o), 32'd1);
            tick();
        end
        bus_gnt_i = 1'b1;
        tick();
        bus_gnt_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput($sformatf("wait resp%0d d_valid", i), 32'(d_valid_o), 32'd0);
            checkOutput($sformatf("wait resp%0d busy", i), 32'(busy_o), 32'd1);
            tick();
        end
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'hCAFE_F00D;
        #1;
        checkOutput("wait d_valid", 32'(d_valid_o), 32'd1);
        checkOutput("wait d_rdata", d_rdata_o, 32'hCAFE_F00D);
        checkOutput("wait if_valid", 32'(if_valid_o), 32'd0);
        tick();
        bus_rvalid_i = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        checkOutput("wait single pulse", 32'(d_valid_o), 32'd0);

        // Spurious response in IDLE and in REQ
        bus_rvalid_i = 1'b1;
        #1;
        checkOutput("spurious idle if_valid", 32'(if_valid_o), 32'd0);
        checkOutput("spurious idle d_valid", 32'(d_valid_o), 32'd0);
        tick();
        checkOutput("spurious idle state", 32'(dut.state_q), 32'(IDLE));
        bus_rvalid_i = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b1, 4'h0, 32'h0000_0400, 32'h0);
        tick();
        bus_rvalid_i = 1'b1;
        #1;
        checkOutput("spurious req d_valid", 32'(d_valid_o), 32'd0);
        checkOutput("spurious req if_valid", 32'(if_valid_o), 32'd0);
        tick();
        checkOutput("spurious req state", 32'(dut.state_q), 32'(REQ));
        bus_rvalid_i = 1'b0;
        bus_gnt_i    = 1'b1;
        tick();
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'h0000_5555;
        #1;
        checkOutput("spurious then real d_valid", 32'(d_valid_o), 32'd1);
        tick();
        bus_rvalid_i = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);

        // Reset asserted during RESP, then a late response
        applyStimulus(1'b1, 32'h0000_0080, 1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        bus_gnt_i = 1'b1;
        tick();
        bus_gnt_i = 1'b0;
        checkOutput("midreset in RESP", 32'(dut.state_q), 32'(RESP));
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset state", 32'(dut.state_q), 32'(IDLE));
        checkOutput("midreset bus_req", 32'(bus_req_o), 32'd0);
        checkOutput("midreset bus_addr", bus_addr_o, 32'h0);
        checkOutput("midreset busy", 32'(busy_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'h7777_7777;
        #1;
        checkOutput("late rvalid if_valid", 32'(if_valid_o), 32'd0);
        checkOutput("late rvalid if_rdata", if_rdata_o, 32'h0);
        tick();
        checkOutput("late rvalid state", 32'(dut.state_q), 32'(IDLE));
        bus_rvalid_i = 1'b0;

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
